// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads instruction memory combinationally,
// and buffers fetched words with their PCs for decode.
module fetch_queue #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pcplus8,
   output logic        out_oob
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [32:0] OOB_LIMIT = 33'(IMEM_WORDS) * 33'd4;

   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0] ent_pc_q    [DEPTH];
   logic [31:0] ent_instr_q [DEPTH];
   logic        ent_oob_q   [DEPTH];

   logic head_valid;
   logic deq;
   logic enq;
   logic fetch_oob;

   assign imem_a     = pc_q;
   assign head_valid = (count_q != '0);
   assign out_valid  = head_valid & ~redirect;
   assign deq        = out_valid & out_ready;
   assign enq        = ~redirect & ((count_q != FULL) | deq);
   assign fetch_oob  = ({1'b0, pc_q} >= OOB_LIMIT);

   // Empty buffer presents zeros rather than stale entry contents.
   assign out_instr   = head_valid ? ent_instr_q[rd_ptr_q] : '0;
   assign out_pc      = head_valid ? ent_pc_q[rd_ptr_q] : '0;
   assign out_oob     = head_valid ? ent_oob_q[rd_ptr_q] : 1'b0;
   assign out_pcplus8 = out_pc + 32'd8;

   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         ent_pc_q[wr_ptr_q]    <= pc_q;
         ent_instr_q[wr_ptr_q] <= imem_rd;
         ent_oob_q[wr_ptr_q]   <= fetch_oob;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirect,
// out-of-range tagging and mid-run reset.
module tb_fetch_queue;

   logic        clk;
   logic        reset;
   logic [31:0] imem_a;
   logic [31:0] imem_rd;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus8;
   logic        out_oob;

   int n_assert = 0;
   int n_fail   = 0;

   fetch_queue #(
      .RESET_PC   (32'h0000_0000),
      .DEPTH      (2),
      .IMEM_WORDS (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_a      (imem_a),
      .imem_rd     (imem_rd),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_pcplus8 (out_pcplus8),
      .out_oob     (out_oob)
   );

   // Memory word k holds E000_0000 + k.
   assign imem_rd = 32'hE000_0000 + (imem_a >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b1;
      smp();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_pc8", out_pcplus8, 32'd8);
      chk("rst_oob", 32'(out_oob), 32'd0);
      chk("rst_imem_a", imem_a, 32'd0);

      // Streaming with out_ready high
      nxt(); reset = 1'b0; smp();
      chk("a_valid", 32'(out_valid), 32'd0);
      chk("a_imem_a", imem_a, 32'd0);
      nxt(); smp();
      chk("b_valid", 32'(out_valid), 32'd1);
      chk("b_pc", out_pc, 32'h0);
      chk("b_instr", out_instr, 32'hE000_0000);
      chk("b_pc8", out_pcplus8, 32'h8);
      nxt(); smp();
      chk("c_valid", 32'(out_valid), 32'd1);
      chk("c_pc", out_pc, 32'h4);
      chk("c_instr", out_instr, 32'hE000_0001);
      chk("c_pc8", out_pcplus8, 32'hC);
      nxt(); smp();
      chk("d_pc", out_pc, 32'h8);
      chk("d_instr", out_instr, 32'hE000_0002);
      chk("d_imem_a", imem_a, 32'hC);

      // Restart, then hold off decode for 5 cycles
      nxt(); reset = 1'b1; out_ready = 1'b0; smp();
      nxt(); reset = 1'b0; smp();
      chk("bp_a_valid", 32'(out_valid), 32'd0);
      nxt(); smp();
      chk("bp_b_valid", 32'(out_valid), 32'd1);
      chk("bp_b_pc", out_pc, 32'h0);
      chk("bp_b_imem_a", imem_a, 32'h4);
      for (int i = 0; i < 4; i++) begin
         nxt(); smp();
      end
      chk("bp_f_valid", 32'(out_valid), 32'd1);
      chk("bp_f_pc", out_pc, 32'h0);
      chk("bp_f_instr", out_instr, 32'hE000_0000);
      chk("bp_f_imem_a", imem_a, 32'h8);
      nxt(); out_ready = 1'b1; smp();
      chk("rel_g_valid", 32'(out_valid), 32'd1);
      chk("rel_g_pc", out_pc, 32'h0);
      nxt(); smp();
      chk("rel_h_valid", 32'(out_valid), 32'd1);
      chk("rel_h_pc", out_pc, 32'h4);
      nxt(); smp();
      chk("rel_i_valid", 32'(out_valid), 32'd1);
      chk("rel_i_pc", out_pc, 32'h8);
      nxt(); out_ready = 1'b0; smp();
      chk("j_pc", out_pc, 32'hC);

      // Redirect while full
      nxt(); redirect = 1'b1; redirect_pc = 32'h0000_0043; smp();
      chk("rd1_valid", 32'(out_valid), 32'd0);
      chk("rd1_imem_a", imem_a, 32'h14);
      nxt(); redirect = 1'b0; out_ready = 1'b1; smp();
      chk("rd1_n1_valid", 32'(out_valid), 32'd0);
      chk("rd1_n1_imem_a", imem_a, 32'h40);
      nxt(); smp();
      chk("rd1_n2_valid", 32'(out_valid), 32'd1);
      chk("rd1_n2_pc", out_pc, 32'h40);
      chk("rd1_n2_instr", out_instr, 32'hE000_0010);
      nxt(); smp();
      chk("n_pc", out_pc, 32'h44);

      // Redirect with a valid head and out_ready high
      nxt(); redirect = 1'b1; redirect_pc = 32'h0000_00FC; smp();
      chk("rd2_valid", 32'(out_valid), 32'd0);
      nxt(); redirect = 1'b0; smp();
      chk("rd2_n1_valid", 32'(out_valid), 32'd0);
      chk("rd2_n1_imem_a", imem_a, 32'hFC);
      nxt(); smp();
      chk("rd2_n2_valid", 32'(out_valid), 32'd1);
      chk("rd2_n2_pc", out_pc, 32'hFC);
      chk("rd2_n2_instr", out_instr, 32'hE000_003F);
      chk("rd2_n2_oob", 32'(out_oob), 32'd0);
      nxt(); smp();
      chk("oob_100_pc", out_pc, 32'h100);
      chk("oob_100_oob", 32'(out_oob), 32'd1);
      chk("oob_100_pc8", out_pcplus8, 32'h108);
      nxt(); smp();
      chk("oob_104_pc", out_pc, 32'h104);
      chk("oob_104_oob", 32'(out_oob), 32'd1);

      // Fill, then reset mid-run
      nxt(); out_ready = 1'b0; smp();
      chk("s_pc", out_pc, 32'h108);
      nxt(); reset = 1'b1; smp();
      chk("t_pc", out_pc, 32'h108);
      chk("t_imem_a", imem_a, 32'h110);
      nxt(); reset = 1'b0; smp();
      chk("rst2_valid", 32'(out_valid), 32'd0);
      chk("rst2_imem_a", imem_a, 32'h0);
      nxt(); smp();
      chk("rst2_n2_valid", 32'(out_valid), 32'd1);
      chk("rst2_n2_pc", out_pc, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the instruction memory and downstream of reset and branch resolution. It owns the program counter, drives the word-aligned fetch address into the combinational-read instruction memory, and captures each returned word with its PC into a small circular buffer. Decode consumes the buffer through a valid/ready handshake. A redirect from execute flushes wrong-path entries and restarts fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, buffer entries; power of two, at least 2.
- IMEM_WORDS, 64, instruction memory size in 32-bit words; sets the out-of-range check.

Ports:
- clk, in, 1, sole clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- imem_a, out, 32, fetch address; equals the PC register.
- imem_rd, in, 32, instruction word returned combinationally for imem_a.
- redirect, in, 1, flush the buffer and load a new PC.
- redirect_pc, in, 32, target PC; bits [1:0] are ignored and forced to 0.
- out_valid, out, 1, head entry is presented to decode.
- out_ready, in, 1, decode accepts the head entry.
- out_instr, out, 32, head instruction.
- out_pc, out, 32, PC of the head instruction.
- out_pcplus8, out, 32, out_pc + 8 (ARM R15 read value).
- out_oob, out, 1, head entry was fetched from an address at or above IMEM_WORDS*4.

## Operation
- State: pc, entry array {pc, instr, oob}[DEPTH], rd_ptr, wr_ptr, and count (0..DEPTH).
- Reset: pc = RESET_PC, rd_ptr = 0, wr_ptr = 0, count = 0. All outputs are then out_valid = 0, out_instr = 0, out_pc = 0, out_pcplus8 = 8, out_oob = 0, imem_a = RESET_PC. Reset overrides redirect.
- imem_a = pc. The fetched word is imem_rd in the same cycle.
- deq = out_valid & out_ready.
- enq = ~redirect & (count < DEPTH | deq).
- On enq: entry[wr_ptr] = {pc, imem_rd, pc >= IMEM_WORDS*4}, wr_ptr increments, pc = pc + 4. pc wraps modulo 2^32.
- On deq: rd_ptr increments.
- Pointers wrap modulo DEPTH.
- count updates by +enq - deq. Simultaneous enq and deq while full is legal and leaves count = DEPTH.
- While full and out_ready = 0, pc holds and imem_a is stable.
- Redirect has priority over enq and deq:
  - count = 0 and rd_ptr = wr_ptr = 0.
  - pc = {redirect_pc[31:2], 2'b00}.
  - No entry is written that cycle.
- out_valid = (count != 0) & ~redirect. A head entry never completes a handshake in a redirect cycle.
- out_instr, out_pc and out_oob come combinationally from entry[rd_ptr]. They read 0 whenever count = 0.
- out_pcplus8 = out_pc + 8, modulo 2^32.
- out-of-range fetches are still enqueued, with out_oob = 1. The block never halts on its own.

## Timing
- Fetch-to-present latency is 1 cycle: the word fetched at edge N is on out_* after edge N.
- First valid output: out_valid = 1 in the cycle after reset deasserts, with out_pc = RESET_PC.
- Throughput: 1 instruction per cycle while out_ready = 1 steadily.
- Redirect asserted in cycle N:
  - out_valid = 0 in cycle N.
  - pc = target during cycle N+1.
  - The target instruction is presented in cycle N+2 and no earlier.
- Backpressure: with out_ready = 0, the buffer fills after DEPTH fetches. The head entry and its outputs hold stable until accepted.
- Reset asserted mid-operation discards all entries at that edge.

## Test plan
- Reset release with RESET_PC = 0, memory word k = 32'hE000_0000 + k, out_ready = 1 -> out_pc sequence 0,4,8,... from the first cycle after reset; out_instr = E000_0000, E000_0001, ...; out_pcplus8 = out_pc + 8.
- out_ready = 0 for 5 cycles after the first valid -> count saturates at 2; pc holds at 8; out_pc stays 0. On release, 0, 4, 8 are delivered in order with no gap or duplicate.
- redirect = 1 with redirect_pc = 32'h0000_0043 while full -> out_valid = 0 that cycle. The next cycle has out_valid = 0 and imem_a = 32'h40. The cycle after presents out_pc = 32'h40. No old entry is ever accepted.
- redirect asserted in the same cycle as out_ready = 1 with a valid head -> no handshake occurs. The old head is not re-presented afterwards.
- redirect_pc = 32'hFC with IMEM_WORDS = 64 -> out_oob = 0 for 0xFC. out_oob = 1 for 0x100 and 0x104.
- reset asserted for 1 cycle while full and out_ready = 0 -> the next cycle has out_valid = 0 and imem_a = RESET_PC. The cycle after presents out_pc = RESET_PC.
